// File: rtl/dom_handshake_sync_rx_if.sv
// ---------------------------------------------------------------------------
// dom_handshake_sync_rx_if
// Bundles the receive-side 4-phase req/ack handshake and its data path.
//   req_i      : request level from the source domain (asynchronous)
//   data_i     : source data, held stable while the request is pending
//   ack_o      : acknowledge level returned to the source domain
//   valid_o    : one-cycle pulse marking a fresh capture on data_o
//   data_o     : captured data, held until the next capture
//   xfer_cnt_o : completed-transfer counter (wraps)
// master = source/stimulus side, slave = the receiver block.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface dom_handshake_sync_rx_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
);
  logic              req_i;
  logic [DATA_W-1:0] data_i;
  logic              ack_o;
  logic              valid_o;
  logic [DATA_W-1:0] data_o;
  logic [CNT_W-1:0]  xfer_cnt_o;

  modport master (
    output req_i,
    output data_i,
    input  ack_o,
    input  valid_o,
    input  data_o,
    input  xfer_cnt_o
  );

  modport slave (
    input  req_i,
    input  data_i,
    output ack_o,
    output valid_o,
    output data_o,
    output xfer_cnt_o
  );
endinterface

// File: rtl/dom_handshake_sync_rx.sv
// ---------------------------------------------------------------------------
// dom_handshake_sync_rx
// Destination-domain receive side of a 4-phase req/ack CDC handshake.
// The request level is passed through a SYNC_STAGES flop chain; the data bus
// is never synchronized bitwise but sampled once, when the FSM leaves IDLE,
// by which time the synchronizer delay guarantees it has settled.
// Ports:
//   clk_i    : destination clock, all state on the rising edge
//   resetn_i : asynchronous active-low reset
//   hs       : handshake bundle (slave modport), see dom_handshake_sync_rx_if
// Parameters:
//   DATA_W      : crossed data width
//   SYNC_STAGES : request synchronizer depth, legal 2..4
//   CNT_W       : completed-transfer counter width (wraps silently)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module dom_handshake_sync_rx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic                   clk_i,
  input  logic                   resetn_i,
  dom_handshake_sync_rx_if.slave hs
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACK_HI   = 2'd1,
    ST_WAIT_LOW = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_req_s;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic                   r_ack;
  logic                   w_ack_nxt;
  logic                   r_valid;
  logic                   w_valid_nxt;
  logic [DATA_W-1:0]      r_data;
  logic [DATA_W-1:0]      w_data_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;

  // Request synchronizer: plain shift chain, nothing between the flops.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], hs.req_i};
    end
  end

  assign w_req_s = r_sync[SYNC_STAGES-1];

  // FSM state and registered outputs.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_state <= ST_IDLE;
      r_ack   <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= w_ack_nxt;
      r_valid <= w_valid_nxt;
      r_data  <= w_data_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = r_ack;
    w_valid_nxt = 1'b0;
    w_data_nxt  = r_data;
    w_cnt_nxt   = r_cnt;

    case (r_state)
      ST_IDLE: begin
        if (w_req_s) begin
          // The only cycle data_i is looked at.
          w_data_nxt  = hs.data_i;
          w_valid_nxt = 1'b1;
          w_ack_nxt   = 1'b1;
          w_state_nxt = ST_ACK_HI;
        end else begin
          w_valid_nxt = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end

      ST_ACK_HI: begin
        // Spacer state: keeps valid_o to one cycle even if req_s has
        // already dropped (protocol violation by the source).
        w_valid_nxt = 1'b0;
        w_ack_nxt   = 1'b1;
        w_state_nxt = ST_WAIT_LOW;
      end

      ST_WAIT_LOW: begin
        if (!w_req_s) begin
          w_ack_nxt   = 1'b0;
          w_cnt_nxt   = r_cnt + CNT_W'(1);
          w_state_nxt = ST_IDLE;
        end else begin
          w_ack_nxt   = 1'b1;
          w_state_nxt = ST_WAIT_LOW;
        end
      end

      default: begin
        w_ack_nxt   = 1'b0;
        w_valid_nxt = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign hs.ack_o      = r_ack;
  assign hs.valid_o    = r_valid;
  assign hs.data_o     = r_data;
  assign hs.xfer_cnt_o = r_cnt;

endmodule

// File: tb/tb_dom_handshake_sync_rx.sv
// ---------------------------------------------------------------------------
// tb_dom_handshake_sync_rx
// Directed bench for dom_handshake_sync_rx (DATA_W=8, SYNC_STAGES=2, CNT_W=4).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dom_handshake_sync_rx;

  logic clk     = 1'b0;
  logic src_clk = 1'b0;
  logic resetn  = 1'b0;

  int errors = 0;
  int checks = 0;

  dom_handshake_sync_rx_if #(.DATA_W(8), .CNT_W(4)) hs_if ();

  dom_handshake_sync_rx #(
    .DATA_W     (8),
    .SYNC_STAGES(2),
    .CNT_W      (4)
  ) dut (
    .clk_i   (clk),
    .resetn_i(resetn),
    .hs      (hs_if)
  );

  always #5 clk = ~clk;
  always #11.667 src_clk = ~src_clk;

  // Source-side synchronizer of ack for the behavioural source model.
  logic ack_s1 = 1'b0;
  logic ack_s2 = 1'b0;
  always @(posedge src_clk) begin
    ack_s1 <= hs_if.ack_o;
    ack_s2 <= ack_s1;
  end

  // Capture monitor for valid pulses.
  logic       mon_en = 1'b0;
  logic [7:0] mon_q[$];
  always @(posedge clk) begin
    #1;
    if (mon_en && hs_if.valid_o) mon_q.push_back(hs_if.data_o);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn       = 1'b0;
    hs_if.req_i  = 1'b1;
    hs_if.data_i = 8'hFF;
    #2;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (hs_if.ack_o !== 1'b0) begin
        errors++; $display("FAIL reset_ack cyc=%0d got=%b exp=0", i, hs_if.ack_o);
      end
      checks++;
      if (hs_if.valid_o !== 1'b0) begin
        errors++; $display("FAIL reset_valid cyc=%0d got=%b exp=0", i, hs_if.valid_o);
      end
      checks++;
      if (hs_if.data_o !== 8'h00) begin
        errors++; $display("FAIL reset_data cyc=%0d got=%h exp=00", i, hs_if.data_o);
      end
      checks++;
      if (hs_if.xfer_cnt_o !== 4'd0) begin
        errors++; $display("FAIL reset_cnt cyc=%0d got=%0d exp=0", i, hs_if.xfer_cnt_o);
      end
    end
    hs_if.req_i  = 1'b0;
    hs_if.data_i = 8'h00;
    tick();
    resetn = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_single();
    hs_if.data_i = 8'hA5;
    hs_if.req_i  = 1'b1;
    tick(); // edge N
    tick(); // edge N+1
    checks++;
    if (hs_if.valid_o !== 1'b0) begin
      errors++; $display("FAIL single_early_valid got=%b exp=0", hs_if.valid_o);
    end
    tick(); // edge N+2
    checks++;
    if (hs_if.valid_o !== 1'b1) begin
      errors++; $display("FAIL single_valid got=%b exp=1", hs_if.valid_o);
    end
    checks++;
    if (hs_if.data_o !== 8'hA5) begin
      errors++; $display("FAIL single_data got=%h exp=a5", hs_if.data_o);
    end
    checks++;
    if (hs_if.ack_o !== 1'b1) begin
      errors++; $display("FAIL single_ack got=%b exp=1", hs_if.ack_o);
    end
    tick(); // edge N+3
    checks++;
    if (hs_if.valid_o !== 1'b0) begin
      errors++; $display("FAIL single_valid_width got=%b exp=0", hs_if.valid_o);
    end
    hs_if.req_i = 1'b0;
    tick(); // edge M
    tick(); // edge M+1
    checks++;
    if (hs_if.ack_o !== 1'b1) begin
      errors++; $display("FAIL single_ack_hold got=%b exp=1", hs_if.ack_o);
    end
    tick(); // edge M+2
    checks++;
    if (hs_if.ack_o !== 1'b0) begin
      errors++; $display("FAIL single_ack_release got=%b exp=0", hs_if.ack_o);
    end
    checks++;
    if (hs_if.xfer_cnt_o !== 4'd1) begin
      errors++; $display("FAIL single_cnt got=%0d exp=1", hs_if.xfer_cnt_o);
    end
  endtask

  task automatic test_short_pulse();
    int pulses = 0;
    hs_if.data_i = 8'h3C;
    hs_if.req_i  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (hs_if.valid_o === 1'b1) pulses++;
    end
    hs_if.req_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (hs_if.valid_o === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 1) begin
      errors++; $display("FAIL short_pulses got=%0d exp=1", pulses);
    end
    checks++;
    if (hs_if.data_o !== 8'h3C) begin
      errors++; $display("FAIL short_data got=%h exp=3c", hs_if.data_o);
    end
    checks++;
    if (hs_if.ack_o !== 1'b0) begin
      errors++; $display("FAIL short_ack got=%b exp=0", hs_if.ack_o);
    end
    checks++;
    if (hs_if.xfer_cnt_o !== 4'd2) begin
      errors++; $display("FAIL short_cnt got=%0d exp=2", hs_if.xfer_cnt_o);
    end
  endtask

  task automatic test_long_hold();
    int pulses = 0;
    hs_if.data_i = 8'h77;
    hs_if.req_i  = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (hs_if.valid_o === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 1) begin
      errors++; $display("FAIL long_pulses got=%0d exp=1", pulses);
    end
    checks++;
    if (hs_if.ack_o !== 1'b1) begin
      errors++; $display("FAIL long_ack_held got=%b exp=1", hs_if.ack_o);
    end
    hs_if.req_i = 1'b0;
    tick(); // edge M
    tick(); // edge M+1
    checks++;
    if (hs_if.ack_o !== 1'b1) begin
      errors++; $display("FAIL long_ack_m1 got=%b exp=1", hs_if.ack_o);
    end
    tick(); // edge M+2
    checks++;
    if (hs_if.ack_o !== 1'b0) begin
      errors++; $display("FAIL long_ack_m2 got=%b exp=0", hs_if.ack_o);
    end
    checks++;
    if (hs_if.xfer_cnt_o !== 4'd3) begin
      errors++; $display("FAIL long_cnt got=%0d exp=3", hs_if.xfer_cnt_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_cnt;
    int         budget;
    bit         stuck = 1'b0;
    // Start from a zeroed counter so the 15->0 wrap falls inside the run.
    #3 resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    mon_q.delete();
    mon_en = 1'b1;
    for (int d = 0; d < 17 && !stuck; d++) begin
      @(posedge src_clk); #1;
      hs_if.data_i = 8'(d);
      hs_if.req_i  = 1'b1;
      budget = 0;
      while (ack_s2 !== 1'b1 && budget < 100) begin
        @(posedge src_clk); #1;
        budget++;
      end
      if (budget >= 100) begin
        checks++; errors++; stuck = 1'b1;
        $display("FAIL b2b_ack_rise_timeout xfer=%0d got=0 exp=1", d);
      end
      hs_if.req_i = 1'b0;
      budget = 0;
      while (ack_s2 !== 1'b0 && budget < 100 && !stuck) begin
        @(posedge src_clk); #1;
        budget++;
      end
      if (budget >= 100) begin
        checks++; errors++; stuck = 1'b1;
        $display("FAIL b2b_ack_fall_timeout xfer=%0d got=1 exp=0", d);
      end
      exp_cnt = 4'(d + 1);
      checks++;
      if (hs_if.xfer_cnt_o !== exp_cnt) begin
        errors++; $display("FAIL b2b_cnt xfer=%0d got=%0d exp=%0d", d, hs_if.xfer_cnt_o, exp_cnt);
      end
    end
    for (int i = 0; i < 10; i++) tick();
    mon_en = 1'b0;
    checks++;
    if (mon_q.size() !== 17) begin
      errors++; $display("FAIL b2b_pulse_count got=%0d exp=17", mon_q.size());
    end
    for (int i = 0; i < 17; i++) begin
      checks++;
      if (i >= mon_q.size()) begin
        errors++; $display("FAIL b2b_data idx=%0d got=missing exp=%0d", i, i);
      end else if (mon_q[i] !== 8'(i)) begin
        errors++; $display("FAIL b2b_data idx=%0d got=%0d exp=%0d", i, mon_q[i], i);
      end
    end
    checks++;
    if (hs_if.xfer_cnt_o !== 4'd1) begin
      errors++; $display("FAIL b2b_final_cnt got=%0d exp=1", hs_if.xfer_cnt_o);
    end
  endtask

  task automatic test_reset_mid();
    hs_if.data_i = 8'hC3;
    hs_if.req_i  = 1'b1;
    for (int i = 0; i < 5; i++) tick(); // now in WAIT_LOW, ack high
    checks++;
    if (hs_if.ack_o !== 1'b1) begin
      errors++; $display("FAIL mid_pre_ack got=%b exp=1", hs_if.ack_o);
    end
    #3 resetn = 1'b0;
    #1;
    checks++;
    if (hs_if.ack_o !== 1'b0) begin
      errors++; $display("FAIL mid_ack got=%b exp=0", hs_if.ack_o);
    end
    checks++;
    if (hs_if.xfer_cnt_o !== 4'd0) begin
      errors++; $display("FAIL mid_cnt got=%0d exp=0", hs_if.xfer_cnt_o);
    end
    checks++;
    if (hs_if.data_o !== 8'h00) begin
      errors++; $display("FAIL mid_data got=%h exp=00", hs_if.data_o);
    end
    hs_if.req_i = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (hs_if.ack_o !== 1'b0 || hs_if.valid_o !== 1'b0) begin
      errors++; $display("FAIL mid_idle got=ack%b/valid%b exp=0/0", hs_if.ack_o, hs_if.valid_o);
    end
    hs_if.data_i = 8'h5A;
    hs_if.req_i  = 1'b1;
    tick();
    tick();
    tick(); // edge N+2
    checks++;
    if (hs_if.valid_o !== 1'b1 || hs_if.data_o !== 8'h5A) begin
      errors++; $display("FAIL mid_rehs_capture got=valid%b/%h exp=1/5a", hs_if.valid_o, hs_if.data_o);
    end
    hs_if.req_i = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (hs_if.ack_o !== 1'b0) begin
      errors++; $display("FAIL mid_rehs_ack got=%b exp=0", hs_if.ack_o);
    end
    checks++;
    if (hs_if.xfer_cnt_o !== 4'd1) begin
      errors++; $display("FAIL mid_rehs_cnt got=%0d exp=1", hs_if.xfer_cnt_o);
    end
  endtask

  initial begin
    hs_if.req_i  = 1'b0;
    hs_if.data_i = 8'h00;
    test_reset();
    test_single();
    test_short_pulse();
    test_long_hold();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dom_handshake_sync_rx.md
Name: dom_handshake_sync_rx

Overview:
Destination-domain receive side of a 4-phase req/ack clock-domain-crossing handshake. Feeds dom_data_reception directly: its valid_o/data_o drive that block's valid_i/data_i.
- Synchronizes an asynchronous req_i from the source domain.
- Captures the source-held data bus once per transfer.
- Emits a single-cycle valid pulse.
- Returns a level ack_o that the source domain synchronizes back.

Parameters:
DATA_W, 8, width of the crossed data bus.
SYNC_STAGES, 2, flops in the req_i synchronizer chain; legal values 2..4.
CNT_W, 4, width of the completed-transfer counter; wraps at 2^CNT_W.

Ports:
clk_i  input  1  destination-domain clock; all state on rising edge.
resetn_i  input  1  asynchronous, active-low reset; deassertion assumed synchronized externally.
req_i  input  1  asynchronous request level from source domain; 4-phase protocol.
data_i  input  DATA_W  source data; held stable by source from req_i rise until it observes ack_o high.
ack_o  output  1  acknowledge level back to source domain; driven directly from a flop.
valid_o  output  1  one-cycle pulse; data_o is valid in that cycle.
data_o  output  DATA_W  captured data; holds its value until the next capture.
xfer_cnt_o  output  CNT_W  count of completed transfers (ack_o fall), modulo 2^CNT_W.

Behaviour:
- Reset (resetn_i low, asynchronous): sync chain=0, state=IDLE, ack_o=0, valid_o=0, data_o=0, xfer_cnt_o=0.
- req_s is the last flop of the SYNC_STAGES chain. No logic is placed between synchronizer flops.
- data_i is sampled only in the cycle the FSM leaves IDLE. The synchronizer delay guarantees data_i has settled. data_i is never synchronized bitwise.
- FSM states: IDLE, ACK_HI, WAIT_LOW.
  - IDLE: if req_s=1, then data_o<=data_i, valid_o<=1, ack_o<=1, go to ACK_HI. Otherwise valid_o<=0 and stay.
  - ACK_HI: valid_o<=0 unconditionally, go to WAIT_LOW. This state guarantees valid_o is exactly one cycle even if req_s drops immediately.
  - WAIT_LOW: if req_s=0, then ack_o<=0, xfer_cnt_o<=xfer_cnt_o+1, go to IDLE. Otherwise hold ack_o=1.
- Latency, SYNC_STAGES=2: req_i first sampled high at edge N -> req_s high after N+1 -> valid_o, ack_o and data_o update at edge N+2. Generally, valid_o rises SYNC_STAGES edges after the first sampling edge.
- Release latency: req_i sampled low at edge M -> ack_o low and counter incremented at edge M+SYNC_STAGES, provided FSM is already in WAIT_LOW.
- One transfer per full 4-phase cycle. A new req_s rise is accepted only from IDLE. req_s still high on return to IDLE is impossible, because WAIT_LOW is exited only on req_s=0.
- Minimum cycles between valid_o pulses: 2 + SYNC_STAGES round trip, i.e. the source cannot complete faster.
- Counter wraps: 2^CNT_W-1 +1 -> 0 with no flag.
- Protocol violation (req_i drops before ack_o seen): still exactly one valid_o pulse. FSM passes through ACK_HI, WAIT_LOW, IDLE normally. No error output.
- req_i glitch shorter than one clock: may or may not be captured. Either way the behaviour is a complete, legal transfer or nothing.
- Reset mid-transfer: all outputs return to reset values asynchronously. Any in-flight transfer is dropped. The source is responsible for re-handshaking after its own reset.
- valid_o and ack_o are never both changing due to combinational paths; all outputs are registered.

Test Plan:
- Reset: hold resetn_i low with req_i=1 and data_i=8'hFF -> ack_o=0, valid_o=0, data_o=8'h00, xfer_cnt_o=0 throughout.
- Single transfer: req_i rises with data_i=8'hA5 sampled at edge N.
  - valid_o=1 only in the cycle after edge N+2, data_o=8'hA5, ack_o=1.
  - Drop req_i -> ack_o=0 two edges later, xfer_cnt_o=1.
- Short req pulse: req_i high for exactly 3 cycles with data 8'h3C -> exactly one valid_o pulse, data_o=8'h3C, ack_o returns 0, xfer_cnt_o increments by 1.
- Long hold: req_i high for 50 cycles -> valid_o pulses once only; ack_o stays 1 until 2 edges after req_i falls.
- Back-to-back: 17 full handshakes with data 0..16 from a behavioural source model on an unrelated clock (ratio 3:7) -> 17 pulses in order 0..16; xfer_cnt_o wraps 15->0 and ends at 1.
- Reset mid-transfer: assert resetn_i while in WAIT_LOW -> ack_o=0 and xfer_cnt_o=0 immediately. After release with req_i low -> FSM in IDLE; next handshake (data 8'h5A) completes normally.
